// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction-word stream into the loader and its byte-write bus to the instruction memory.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit words big-endian into the byte-wide instruction memory, holding the CPU until a zero word.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  imem_loader_if.slave      bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              cpu_hold_o,
  output logic [ADDR_W-2:0] word_count_o
);
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERR} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 4);
  localparam logic [ADDR_W:0] BASE = (ADDR_W+1)'(BASE_ADDR);
  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-2:0] cnt_q, cnt_d;
  logic              room;
  // ptr is one bit wider than the address so it can reach DEPTH without wrapping
  assign room = ptr_q <= LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACCEPT:
        if (!room) state_d = ERR;
        else if (bus.in_valid) begin
          state_d = WRITE;
          word_d  = bus.in_data;
          idx_d   = '0;
        end
      WRITE: begin
        ptr_d = ptr_q + 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == 2'd3) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (word_q == '0) ? DONE : ACCEPT;
        end
      end
      default:
        if (start_i) begin
          state_d = ACCEPT;
          ptr_d   = BASE;
          cnt_d   = '0;
        end
    endcase
  end
  // most significant byte first, matching the fetch side
  assign bus.mem_wdata = word_q[{~idx_q, 3'b000} +: 8];
  assign bus.mem_addr  = ptr_q[ADDR_W-1:0];
  assign bus.mem_we    = state_q == WRITE;
  assign bus.in_ready  = (state_q == ACCEPT) && room;
  assign busy_o        = (state_q == ACCEPT) || (state_q == WRITE);
  assign done_o        = state_q == DONE;
  assign overflow_o    = state_q == ERR;
  assign cpu_hold_o    = busy_o || overflow_o;
  assign word_count_o  = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: three loader configurations share one randomized stimulus; each is checked every cycle against a byte-queue model.
module tb_imem_loader;
  logic        clk = 0, rst = 0, start = 0, in_valid = 0;
  logic [31:0] in_data = 0;
  int          vecs = 0, errs = 0;
  logic [7:0]  prog [12] = '{8'h00, 8'h90, 8'h05, 8'h13, 8'h00, 8'h60, 8'h05, 8'h93, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int AW    = k == 0 ? 10 : k == 1 ? 5 : 6;
    localparam int DEPTH = k == 0 ? 1024 : k == 1 ? 16 : 48;
    localparam int BASE  = k == 2 ? 8 : 0;
    imem_loader_if #(.ADDR_W(AW)) bus ();
    logic          busy, done, ovf, hold;
    logic [AW-2:0] wc;
    logic [7:0]    img [2**AW];
    int            nwr = 0, oob = 0;
    bit            active = 0, term = 0;
    int            fin = 0, ptr = BASE, cnt = 0;
    int            q_addr [$];
    logic [7:0]    q_data [$];
    assign bus.in_valid = in_valid;
    assign bus.in_data  = in_data;
    imem_loader #(.ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .start_i(start), .bus(bus),
      .busy_o(busy), .done_o(done), .overflow_o(ovf), .cpu_hold_o(hold), .word_count_o(wc)
    );
    initial forever begin
      @(posedge clk);
      if (bus.mem_we) begin
        img[bus.mem_addr] = bus.mem_wdata;
        nwr++;
        if (int'(bus.mem_addr) >= DEPTH) oob++;
      end
    end
    // model: a load is a queue of pending byte writes; an accepted word enqueues its four bytes
    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        active = 0; term = 0; fin = 0; ptr = BASE; cnt = 0;
        q_addr.delete(); q_data.delete();
      end else if (!active) begin
        if (start) begin
          active = 1; term = 0; fin = 0; ptr = BASE; cnt = 0;
        end
      end else if (q_data.size() != 0) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        ptr++;
        if (q_data.size() == 0) begin
          cnt++;
          if (term) begin active = 0; fin = 1; end
        end
      end else if (ptr > DEPTH - 4) begin
        active = 0; fin = 2;
      end else if (in_valid) begin
        for (int i = 0; i < 4; i++) begin
          q_addr.push_back(ptr + i);
          q_data.push_back(8'(in_data >> (24 - 8 * i)));
        end
        term = in_data == 0;
      end
    end
    initial forever begin
      @(negedge clk);
      chk("in_ready", k, bus.in_ready, active && q_data.size() == 0 && ptr <= DEPTH - 4);
      chk("mem_we", k, bus.mem_we, q_data.size() != 0);
      if (q_data.size() != 0) begin
        chk("mem_addr", k, bus.mem_addr, q_addr[0]);
        chk("mem_wdata", k, bus.mem_wdata, q_data[0]);
      end
      chk("busy", k, busy, active);
      chk("done", k, done, fin == 1);
      chk("overflow", k, ovf, fin == 2);
      chk("cpu_hold", k, hold, active || fin == 2);
      chk("word_count", k, wc, cnt);
    end
  end

  function automatic logic [7:0] rd(input int k, input int a);
    return k == 0 ? g[0].img[a % 1024] : k == 1 ? g[1].img[a % 32] : g[2].img[a % 64];
  endfunction

  task automatic chk_word(input string name, input int k, input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) chk(name, k, rd(k, a + i), 8'(w >> (24 - 8 * i)));
  endtask

  task automatic pulse_start;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [31:0] w, input int gap, input bit noise, output int waited);
    in_valid = 0;
    repeat (gap) begin
      in_data = $urandom;
      start = noise && $urandom_range(3) == 0;
      @(negedge clk);
    end
    start = 0;
    in_valid = 1;
    waited = 0;
    while (!g[0].bus.in_ready && waited < 40) begin
      in_data = $urandom;
      waited++;
      @(negedge clk);
    end
    in_data = w;
    @(negedge clk);
    in_valid = 0;
    in_data = $urandom;
    if (waited >= 40) begin
      vecs++;
      errs++;
      $display("FAIL handshake: in_ready stayed 0 for %0d cycles, expected 1", waited);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, n0;
    #2 rst = 1;
    #20 rst = 0;
    @(negedge clk);
    chk("rst_busy", 0, g[0].busy, 0);
    chk("rst_hold", 0, g[0].hold, 0);
    chk("rst_wc", 0, g[0].wc, 0);
    // program load from base 0 with back-to-back valid
    n0 = g[0].nwr;
    pulse_start();
    send(32'h00900513, 0, 0, w);
    chk("first_hs_wait", 0, w, 0);
    send(32'h00600593, 0, 0, w);
    chk("hs_gap", 0, w, 4);
    send(32'h00000000, 0, 0, w);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 12; i++) chk("prog_byte", 0, rd(0, i), prog[i]);
    for (int i = 0; i < 12; i++) chk("prog_byte_base8", 2, rd(2, 8 + i), prog[i]);
    chk("prog_done", 0, g[0].done, 1);
    chk("prog_wc", 0, g[0].wc, 3);
    chk("prog_hold", 0, g[0].hold, 0);
    chk("prog_writes", 0, g[0].nwr - n0, 12);
    // start from DONE clears done and word_count
    pulse_start();
    chk("restart_done", 0, g[0].done, 0);
    chk("restart_wc", 0, g[0].wc, 0);
    chk("restart_busy", 0, g[0].busy, 1);
    send(32'h0, 0, 0, w);
    repeat (6) @(negedge clk);
    chk("zero_only_wc", 0, g[0].wc, 1);
    // start while busy is ignored
    pulse_start();
    send(32'h12345678, 0, 0, w);
    start = 1;
    @(negedge clk);
    start = 0;
    send(32'h0, 0, 0, w);
    repeat (6) @(negedge clk);
    chk("busy_start_wc", 0, g[0].wc, 2);
    chk_word("busy_start_w0", 0, 0, 32'h12345678);
    chk_word("busy_start_w1", 0, 4, 32'h0);
    // gapped valid, base 8 instance
    pulse_start();
    send(32'hA1B2C3D4, 2, 0, w);
    send(32'h0BADF00D, 2, 0, w);
    send(32'h0, 2, 0, w);
    repeat (6) @(negedge clk);
    chk_word("gap_w0", 2, 8, 32'hA1B2C3D4);
    chk_word("gap_w1", 2, 12, 32'h0BADF00D);
    chk_word("gap_w2", 2, 16, 32'h0);
    // fill the 16-byte instance exactly, then one more word
    pulse_start();
    for (int i = 1; i <= 5; i++) send(32'h11111111 * i, 0, 0, w);
    chk("ovf_flag", 1, g[1].ovf, 1);
    chk("ovf_hold", 1, g[1].hold, 1);
    chk("ovf_ready", 1, g[1].bus.in_ready, 0);
    chk("ovf_busy", 1, g[1].busy, 0);
    chk("ovf_wc", 1, g[1].wc, 4);
    chk("ovf_oob", 1, g[1].oob, 0);
    chk_word("ovf_last", 1, 12, 32'h44444444);
    send(32'h0, 0, 0, w);
    repeat (6) @(negedge clk);
    chk("ovf_sticky", 1, g[1].ovf, 1);
    // reset during byte 2 of the first word
    pulse_start();
    send(32'hDEADBEEF, 0, 0, w);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rst_mid_we", 0, g[0].bus.mem_we, 0);
    chk("rst_mid_busy", 0, g[0].busy, 0);
    chk("rst_mid_ready", 0, g[0].bus.in_ready, 0);
    chk("rst_mid_hold", 0, g[0].hold, 0);
    chk("rst_mid_b0", 0, rd(0, 0), 8'hDE);
    chk("rst_mid_b1", 0, rd(0, 1), 8'hAD);
    #4 rst = 0;
    @(negedge clk);
    pulse_start();
    send(32'h00900513, 0, 0, w);
    send(32'h0, 0, 0, w);
    repeat (6) @(negedge clk);
    chk_word("reload_w0", 0, 0, 32'h00900513);
    chk_word("reload_w0_base8", 2, 8, 32'h00900513);
    chk("reload_wc", 0, g[0].wc, 2);
    // randomized loads
    for (int l = 0; l < 30; l++) begin
      repeat ($urandom_range(3)) begin
        in_valid = 1'($urandom);
        in_data = $urandom;
        @(negedge clk);
      end
      in_valid = 0;
      pulse_start();
      repeat ($urandom_range(10)) send($urandom | 32'h1, $urandom_range(3), 1, w);
      send(32'h0, $urandom_range(3), 1, w);
      repeat (6) @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
